// File: rtl/id_register_bank_pkg.sv
// -----------------------------------------------------------------------------
// id_register_bank_pkg
// Shared constants for the decode-stage register file.
//   B_DEFAULT   : default data width of every register and data port
//   D_DEFAULT   : default register address width (bank depth = 2**D)
//   REG_ZERO    : address of the hard-wired zero register
//   RESET_VALUE : value every register and ID/EX output clears to
// -----------------------------------------------------------------------------
package id_register_bank_pkg;

    localparam int B_DEFAULT = 32;
    localparam int D_DEFAULT = 5;

    localparam logic [D_DEFAULT-1:0] REG_ZERO    = {D_DEFAULT{1'b0}};
    localparam logic [B_DEFAULT-1:0] RESET_VALUE = {B_DEFAULT{1'b0}};

endpackage : id_register_bank_pkg

// File: rtl/id_register_bank_mux2.sv
// -----------------------------------------------------------------------------
// id_register_bank_mux2
// Generic 2:1 multiplexer used for the write-back bypass select.
// Ports:
//   item_a   in  W  selected when sel=0 (bank read data)
//   item_b   in  W  selected when sel=1 (write-back data)
//   sel      in  1  select
//   item_out out W  selected item
// -----------------------------------------------------------------------------
module id_register_bank_mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] item_a,
    input  logic [W-1:0] item_b,
    input  logic         sel,
    output logic [W-1:0] item_out
);

    assign item_out = sel ? item_b : item_a;

endmodule : id_register_bank_mux2

// File: rtl/id_register_bank.sv
// -----------------------------------------------------------------------------
// id_register_bank
// Decode-stage register file with write-back bypass, registered ID/EX operand
// outputs (flush > stall > load) and a combinational debug read port.
// Ports:
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous reset, active low
//   RegWrite    in   1  write-back enable
//   write_reg   in   D  write-back destination register
//   write_data  in   B  write-back data
//   read_reg1   in   D  source register rs
//   read_reg2   in   D  source register rt
//   stall       in   1  hold ID/EX outputs
//   flush       in   1  zero ID/EX outputs
//   read_data1  out  B  registered operand 1
//   read_data2  out  B  registered operand 2
//   dbg_reg     in   D  debug read address
//   dbg_data    out  B  combinational bank read, no bypass
// -----------------------------------------------------------------------------
module id_register_bank
    import id_register_bank_pkg::*;
#(
    parameter int B = B_DEFAULT,
    parameter int D = D_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RegWrite,
    input  logic [D-1:0] write_reg,
    input  logic [B-1:0] write_data,
    input  logic [D-1:0] read_reg1,
    input  logic [D-1:0] read_reg2,
    input  logic         stall,
    input  logic         flush,
    output logic [B-1:0] read_data1,
    output logic [B-1:0] read_data2,
    input  logic [D-1:0] dbg_reg,
    output logic [B-1:0] dbg_data
);

    localparam int                DEPTH     = 2 ** D;
    localparam logic [D-1:0]      ADDR_ZERO = D'(REG_ZERO);
    localparam logic [B-1:0]      DATA_ZERO = B'(RESET_VALUE);

    logic [B-1:0] r_bank [0:DEPTH-1];

    logic [D-1:0] w_rd_addr  [0:1];
    logic [B-1:0] w_bank_rd  [0:1];
    logic         w_bypass   [0:1];
    logic [B-1:0] w_mux_out  [0:1];
    logic [B-1:0] w_operand  [0:1];
    logic [B-1:0] r_read_data[0:1];
    logic         w_wr_en;

    // Register 0 is never written, so it stays at its reset value of zero.
    assign w_wr_en = RegWrite && (write_reg != ADDR_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= DATA_ZERO;
            end
        end else if (w_wr_en) begin
            r_bank[write_reg] <= write_data;
        end
    end

    assign w_rd_addr[0] = read_reg1;
    assign w_rd_addr[1] = read_reg2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            assign w_bank_rd[gi] = r_bank[w_rd_addr[gi]];
            // Forward the write-back result when it targets this source, so a
            // write and a dependent read in the same cycle see the new value.
            assign w_bypass[gi]  = RegWrite && (write_reg == w_rd_addr[gi]);

            id_register_bank_mux2 #(
                .W (B)
            ) u_bypass_mux (
                .item_a   (w_bank_rd[gi]),
                .item_b   (write_data),
                .sel      (w_bypass[gi]),
                .item_out (w_mux_out[gi])
            );

            // Zero check wins over bypass: a write-back aimed at r0 must not leak.
            assign w_operand[gi] = (w_rd_addr[gi] == ADDR_ZERO) ? DATA_ZERO : w_mux_out[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_read_data[gi] <= DATA_ZERO;
                end else if (flush) begin
                    r_read_data[gi] <= DATA_ZERO;
                end else if (!stall) begin
                    r_read_data[gi] <= w_operand[gi];
                end
            end
        end
    endgenerate

    assign read_data1 = r_read_data[0];
    assign read_data2 = r_read_data[1];

    assign dbg_data = (dbg_reg == ADDR_ZERO) ? DATA_ZERO : r_bank[dbg_reg];

endmodule : id_register_bank
